// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping core.
package stopwatch_pkg;

    typedef enum logic {
        StRun    = 1'b0,
        StPaused = 1'b1
    } run_state_e;

    localparam logic [3:0] ONES_MAX  = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [7:0] BCD_RESET = 8'h00;

    // BCD increment of a {tens, ones} pair, wrapping 59 -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == ONES_MAX) begin
            r[3:0] = 4'd0;
            if (v[7:4] == TENS_MAX) begin
                r[7:4] = 4'd0;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioning: SYNC_STAGES-flop synchronizer followed by a debouncer
// that accepts a new level after DEBOUNCE_CYCLES consecutive differing cycles.
// rise_o is a registered one-cycle pulse on each accepted 0 -> 1 transition.
module button_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   sync_chain;
    logic                   btn_sync;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;

    assign sync_chain = {sync_q, btn_i};
    assign btn_sync   = sync_q[SYNC_STAGES-1];

    // Count cycles the synchronized input disagrees with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (btn_sync != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = btn_sync;
                cnt_d   = '0;
                rise_d  = btn_sync;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer, counter and accepted-level registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_chain[SYNC_STAGES-1:0];
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: BCD mm:ss counter with run/pause and adjust mode.
// Optional adjust-field blinking is built when STOPWATCH_BLINK_EN is defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       running,
    output logic       blank_min,
    output logic       blank_sec
);

    logic [SYNC_STAGES-1:0] adj_sync_q, sel_sync_q;
    logic [SYNC_STAGES:0]   adj_chain, sel_chain;
    logic                   adj_s, sel_s;
    logic                   pause_rise;
    run_state_e             state_q, state_d;
    logic [7:0]             min_q, min_d;
    logic [7:0]             sec_q, sec_d;

    assign adj_chain = {adj_sync_q, adj};
    assign sel_chain = {sel_sync_q, sel};
    assign adj_s     = adj_sync_q[SYNC_STAGES-1];
    assign sel_s     = sel_sync_q[SYNC_STAGES-1];

    button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pause_db (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (pause_btn),
        .rise_o (pause_rise)
    );

    // Next state and time fields; ticks are judged against the pre-toggle state.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        if (pause_rise) begin
            state_d = (state_q == StRun) ? StPaused : StRun;
        end
        if (adj_s) begin
            if (tick_2hz) begin
                if (sel_s) begin
                    sec_d = bcd_inc(sec_q);
                end else begin
                    min_d = bcd_inc(min_q);
                end
            end
        end else if ((state_q == StRun) && tick_1hz) begin
            sec_d = bcd_inc(sec_q);
            if (sec_q == {TENS_MAX, ONES_MAX}) begin
                min_d = bcd_inc(min_q);
            end
        end
    end

    // Synchronizers, run state and time registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            adj_sync_q <= '0;
            sel_sync_q <= '0;
            state_q    <= StRun;
            min_q      <= BCD_RESET;
            sec_q      <= BCD_RESET;
        end else begin
            adj_sync_q <= adj_chain[SYNC_STAGES-1:0];
            sel_sync_q <= sel_chain[SYNC_STAGES-1:0];
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign running = (state_q == StRun);

`ifdef STOPWATCH_BLINK_EN
    logic phase_q, phase_d;
    logic blank_min_q, blank_sec_q;

    // Blink phase advances at 2 Hz only while adjusting.
    always_comb begin
        phase_d = 1'b0;
        if (adj_s) begin
            phase_d = tick_2hz ? ~phase_q : phase_q;
        end
    end

    // Registered blanking requests derived from the upcoming phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            blank_min_q <= adj_s & phase_d & ~sel_s;
            blank_sec_q <= adj_s & phase_d & sel_s;
        end
    end

    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;
`else
    assign blank_min = 1'b0;
    assign blank_sec = 1'b0;
`endif

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping core of the stopwatch: it produces the BCD `minutes`/`seconds` pair that the 7-segment display stage multiplexes onto the digits. It counts on the 1 Hz tick from the clock divider and toggles run/pause from a debounced button. An adjust mode lets the user step the selected field at 2 Hz. All logic runs on the single system clock; divider outputs are used only as one-cycle enables, never as clocks.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flop stages in each input synchronizer.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable cycles required to accept a new button level. This is 10 ms at 100 MHz.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous and active-high.
- `tick_1hz`  in  1: one-cycle enable pulse at 1 Hz.
- `tick_2hz`  in  1: one-cycle enable pulse at 2 Hz.
- `pause_btn`  in  1: raw, asynchronous pause button level.
- `adj`  in  1: asynchronous level; 1 selects adjust mode.
- `sel`  in  1: asynchronous level; 0 selects minutes, 1 selects seconds.
- `minutes`  out  8: BCD value {tens[7:4], ones[3:0]}, range 00–59.
- `seconds`  out  8: BCD value, same format and range.
- `running`  out  1: 1 in the RUN state, 0 in PAUSED.
- `blank_min`  out  1: requests blanking of the minute digits (see Configuration).
- `blank_sec`  out  1: requests blanking of the second digits.

## Operation
- Reset values:
  - `minutes` = 8'h00, `seconds` = 8'h00.
  - `running` = 1 (state RUN).
  - `blank_min` = `blank_sec` = 0.
  - Blink phase = 0, debouncer output = 0, all synchronizer flops = 0.
- Input conditioning:
  - `pause_btn`, `adj` and `sel` each pass through `SYNC_STAGES` flops.
  - The synchronized `pause_btn` then feeds the debouncer. Its output changes only after the input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any glitch restarts the count.
- State machine (states RUN and PAUSED): a rising edge of the debounced button toggles RUN↔PAUSED. No other transitions exist.
- Normal mode (synchronized `adj` = 0):
  - In RUN, each `tick_1hz` increments `seconds`. Seconds 59 wraps to 00 and carries +1 into `minutes`.
  - Minutes 59 wraps to 00, so 59:59 → 00:00.
  - In PAUSED, both fields hold.
  - `tick_2hz` is ignored.
- Adjust mode (synchronized `adj` = 1):
  - Counting is suspended whatever the state, and `tick_1hz` is ignored.
  - Each `tick_2hz` increments the field chosen by synchronized `sel` by 1, modulo 60, with no carry into the other field.
  - Pause edges still toggle the state. The new state takes effect when `adj` returns to 0.
- BCD arithmetic:
  - Ones digit counts 0–9.
  - Tens digit counts 0–5, incremented on ones 9→0.
  - Out-of-range codes are unreachable; no clamping logic is required.
- Simultaneous events:
  - `tick_1hz` and `tick_2hz` in the same cycle: only the tick valid for the current mode acts.
  - Pause edge and `tick_1hz` in the same cycle: the tick is evaluated against the pre-toggle state.

## Timing
- All outputs are registered.
- A field update is visible on the cycle after the enabling tick is sampled high.
- `adj`/`sel` changes take effect `SYNC_STAGES` cycles after the input changes.
- `running` toggles `SYNC_STAGES + DEBOUNCE_CYCLES + 1` cycles after a clean button edge.
- Reset asserted mid-count clears everything on the next clock edge. The first tick after reset deasserts counts from 00:00.

## Configuration
- `STOPWATCH_BLINK_EN` defined:
  - A blink-phase flop toggles on each `tick_2hz` while in adjust mode and is cleared while not in adjust mode.
  - `blank_min` = adjust mode & phase & `sel`==0.
  - `blank_sec` = adjust mode & phase & `sel`==1.
- `STOPWATCH_BLINK_EN` undefined: `blank_min` and `blank_sec` are tied to 0, and the phase flop is not built.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the RUN/PAUSED state type;
  - BCD limit constants (ONES_MAX = 9, TENS_MAX = 5);
  - the 8'h00 reset constant.
- One sub-module, `button_debounce`: synchronizer plus debounce counter, parameterized by `SYNC_STAGES` and `DEBOUNCE_CYCLES`, with a one-cycle rising-edge pulse output.

## Test plan
The bench uses `DEBOUNCE_CYCLES` = 4.
- Reset, then 60 `tick_1hz` pulses → `minutes` = 8'h01, `seconds` = 8'h00, `running` = 1.
- `adj`=1, `sel`=0, 59 `tick_2hz` → minutes 8'h59; then `sel`=1, 59 `tick_2hz` → seconds 8'h59. Then `adj`=0 and one `tick_1hz` → 8'h00 / 8'h00.
- `pause_btn` held high for 10 cycles → `running`=0, and 5 `tick_1hz` leave the time unchanged. Release, then press again for 10 cycles → `running`=1, and the next tick increments the time.
- `pause_btn` pulse of 3 cycles → `running` unchanged.
- Adjust with `sel`=1 at 00:59, one `tick_2hz` → 00:00 with minutes unchanged. Reset asserted mid-sequence → all outputs at their reset values the next cycle.
- With `STOPWATCH_BLINK_EN`, `adj`=1, `sel`=1, 4 `tick_2hz` → `blank_sec` sequence 1,0,1,0 and `blank_min` stays 0. Without the macro, both stay 0.
